// File: rtl/led_pkg.sv
// Shared encodings, constants and the frame-pattern generator for the LED pattern sequencer.
package led_pkg;

  typedef enum logic [1:0] {
    MODE_CHECKER = 2'd0,
    MODE_COUNTER = 2'd1,
    MODE_WALK    = 2'd2,
    MODE_FILL    = 2'd3
  } mode_e;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_PAUSE = 1'b1
  } run_state_e;

  localparam logic [7:0] LED_ALL_OFF = 8'hFF;
  localparam logic [7:0] CHECK_A     = 8'hAA;
  localparam logic [7:0] CHECK_B     = 8'h55;

  localparam int BTN_RUN   = 0;
  localparam int BTN_STEP  = 1;
  localparam int BTN_MODE  = 2;
  localparam int BTN_SPEED = 3;

  localparam logic [5:0] FILL_LAST = 6'd32;

  // Frame word layout: bits [8*r +: 8] hold row r, so LED index k = row*8+bit is bit k.
  localparam logic [31:0] ROWS_RESET = {CHECK_B, CHECK_A, CHECK_B, CHECK_A};

  function automatic logic [31:0] pattern_rows(input mode_e mode, input logic [31:0] count,
                                               input logic [5:0] fill_n);
    logic [31:0] leds;
    leds = {4{LED_ALL_OFF}};
    case (mode)
      MODE_CHECKER: leds = count[0] ? {CHECK_A, CHECK_B, CHECK_A, CHECK_B} : ROWS_RESET;
      MODE_COUNTER: leds = ~{count[7:0], count[15:8], count[23:16], count[31:24]};
      MODE_WALK:    leds = ~(32'h0000_0001 << count[4:0]);
      MODE_FILL: begin
        if (fill_n >= FILL_LAST) begin
          leds = 32'h0000_0000;
        end else begin
          leds = ~((32'h0000_0001 << fill_n) - 32'h0000_0001);
        end
      end
      default:      leds = {4{LED_ALL_OFF}};
    endcase
    return leds;
  endfunction

endpackage

// File: rtl/button_debounce.sv
// One push-button: 2-FF synchronizer, stability counter and a single-cycle press pulse.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 65536
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic button_n_i,
  output logic press_o
);

  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [1:0]    sync_q;
  logic          stable_q, stable_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          press_q, press_d;

  // The debounced level only follows the synchronized level after a full run of equal samples.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    press_d  = 1'b0;
    if (sync_q[1] != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = sync_q[1];
        cnt_d    = '0;
        press_d  = sync_q[1];
      end else begin
        stable_d = stable_q;
        cnt_d    = cnt_q + CNT_ONE;
        press_d  = 1'b0;
      end
    end else begin
      stable_d = stable_q;
      cnt_d    = '0;
      press_d  = 1'b0;
    end
  end

  // Raw input is active-low; the synchronizer carries an active-high "pressed" level.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q   <= 2'b00;
      stable_q <= 1'b0;
      cnt_q    <= '0;
      press_q  <= 1'b0;
    end else begin
      sync_q   <= {sync_q[0], ~button_n_i};
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      press_q  <= press_d;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/led_pattern_sequencer.sv
// LED pattern sequencer: button-driven run/pause, step, mode and speed control producing
// animated 4x8 row patterns for the matrix scanner.
module led_pattern_sequencer
  import led_pkg::*;
#(
  parameter int TICK_DIV        = 2097152,
  parameter int DEBOUNCE_CYCLES = 65536
) (
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic [3:0] i_button,
  output logic [7:0] o_row0,
  output logic [7:0] o_row1,
  output logic [7:0] o_row2,
  output logic [7:0] o_row3,
  output logic [1:0] o_mode,
  output logic       o_running,
  output logic       o_tick
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_LAST0 = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0] PRESC_LAST1 = PW'((TICK_DIV >> 1) - 1);
  localparam logic [PW-1:0] PRESC_LAST2 = PW'((TICK_DIV >> 2) - 1);
  localparam logic [PW-1:0] PRESC_LAST3 = PW'((TICK_DIV >> 3) - 1);
  localparam logic [PW-1:0] PRESC_ONE   = PW'(1);

  logic [3:0]    press_s;
  logic          run_ev_s, step_ev_s, mode_ev_s, speed_ev_s;
  logic [PW-1:0] presc_last_s;
  logic          tick_s;

  run_state_e    state_q, state_d;
  mode_e         mode_q, mode_d;
  logic [1:0]    speed_q, speed_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [31:0]   count_q, count_d;
  logic [5:0]    fill_q, fill_d;
  logic [31:0]   rows_q, rows_d;
  logic          running_q, running_d;
  logic          tick_q;

  for (genvar g = 0; g < 4; g++) begin : g_btn
    button_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk_i      (i_clock),
      .rst_i      (i_reset),
      .button_n_i (i_button[g]),
      .press_o    (press_s[g])
    );
  end

  assign run_ev_s   = press_s[BTN_RUN];
  assign step_ev_s  = press_s[BTN_STEP];
  assign mode_ev_s  = press_s[BTN_MODE];
  assign speed_ev_s = press_s[BTN_SPEED];

  // Terminal prescaler count for the current speed setting.
  always_comb begin
    case (speed_q)
      2'd0:    presc_last_s = PRESC_LAST0;
      2'd1:    presc_last_s = PRESC_LAST1;
      2'd2:    presc_last_s = PRESC_LAST2;
      2'd3:    presc_last_s = PRESC_LAST3;
      default: presc_last_s = PRESC_LAST0;
    endcase
  end

  // Step is judged against the state before any same-cycle run/pause toggle.
  assign tick_s = (state_q == ST_RUN) ? (presc_q == presc_last_s) : step_ev_s;

  // Next-state for the run FSM, prescaler, speed, mode and pattern count.
  always_comb begin
    if (run_ev_s) begin
      state_d = (state_q == ST_RUN) ? ST_PAUSE : ST_RUN;
    end else begin
      state_d = state_q;
    end
    running_d = (state_d == ST_RUN);

    if (speed_ev_s) begin
      speed_d = speed_q + 2'd1;
    end else begin
      speed_d = speed_q;
    end

    if (speed_ev_s || mode_ev_s) begin
      presc_d = '0;
    end else if (state_q == ST_RUN) begin
      presc_d = (presc_q == presc_last_s) ? '0 : presc_q + PRESC_ONE;
    end else begin
      presc_d = presc_q;
    end

    if (mode_ev_s) begin
      mode_d = mode_e'(mode_q + 2'd1);
    end else begin
      mode_d = mode_q;
    end

    // fill_q tracks count mod 33; 2^32 is not a multiple of 33, so the count wrap restarts it.
    if (mode_ev_s) begin
      count_d = 32'h0000_0000;
      fill_d  = 6'd0;
    end else if (tick_s) begin
      count_d = count_q + 32'h0000_0001;
      fill_d  = ((count_q == 32'hFFFF_FFFF) || (fill_q == FILL_LAST)) ? 6'd0 : fill_q + 6'd1;
    end else begin
      count_d = count_q;
      fill_d  = fill_q;
    end

    rows_d = pattern_rows(mode_d, count_d, fill_d);
  end

  // All sequencer state and registered outputs.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q   <= ST_RUN;
      mode_q    <= MODE_CHECKER;
      speed_q   <= 2'd0;
      presc_q   <= '0;
      count_q   <= 32'h0000_0000;
      fill_q    <= 6'd0;
      rows_q    <= ROWS_RESET;
      running_q <= 1'b1;
      tick_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      speed_q   <= speed_d;
      presc_q   <= presc_d;
      count_q   <= count_d;
      fill_q    <= fill_d;
      rows_q    <= rows_d;
      running_q <= running_d;
      tick_q    <= tick_s;
    end
  end

  assign o_row0    = rows_q[7:0];
  assign o_row1    = rows_q[15:8];
  assign o_row2    = rows_q[23:16];
  assign o_row3    = rows_q[31:24];
  assign o_mode    = mode_q;
  assign o_running = running_q;
  assign o_tick    = tick_q;

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Randomized scoreboard bench for led_pattern_sequencer with a frame-level reference model.
`timescale 1ns/1ps
module tb_led_pattern_sequencer;

  localparam int TICK_DIV = 16;
  localparam int DEB      = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] btn;
  logic [7:0] o_row0, o_row1, o_row2, o_row3;
  logic [1:0] o_mode;
  logic       o_running, o_tick;

  always #5 clk = ~clk;

  led_pattern_sequencer #(.TICK_DIV(TICK_DIV), .DEBOUNCE_CYCLES(DEB)) dut (
    .i_clock(clk), .i_reset(rst), .i_button(btn),
    .o_row0(o_row0), .o_row1(o_row1), .o_row2(o_row2), .o_row3(o_row3),
    .o_mode(o_mode), .o_running(o_running), .o_tick(o_tick)
  );

  typedef struct packed {
    logic [1:0]  mode;
    logic [31:0] rows;
  } exp_t;

  exp_t        sb[$];
  int          tick_times[$];
  int          cyc = 0;
  int          t0 = 0;
  int          n_checks = 0;
  int          n_pass = 0;
  bit          sb_en = 1'b1;
  int          m_mode, m_speed;
  bit          m_running;
  logic [31:0] m_count;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Frame from the mode rules, LED by LED; returns {row0,row1,row2,row3}.
  function automatic logic [31:0] model_rows(input int mode, input logic [31:0] cnt);
    logic [7:0] r [4];
    int p, n;
    for (int i = 0; i < 4; i++) r[i] = 8'hFF;
    case (mode)
      0: begin
        if (cnt[0] == 1'b0) begin r[0] = 8'hAA; r[1] = 8'h55; r[2] = 8'hAA; r[3] = 8'h55; end
        else begin r[0] = 8'h55; r[1] = 8'hAA; r[2] = 8'h55; r[3] = 8'hAA; end
      end
      1: begin r[3] = ~cnt[7:0]; r[2] = ~cnt[15:8]; r[1] = ~cnt[23:16]; r[0] = ~cnt[31:24]; end
      2: begin p = int'(cnt % 32); r[p / 8][p % 8] = 1'b0; end
      3: begin
        n = int'(cnt % 33);
        for (int k = 0; k < 32; k++) if (k < n) r[k / 8][k % 8] = 1'b0;
      end
      default: ;
    endcase
    return {r[0], r[1], r[2], r[3]};
  endfunction

  function automatic logic [31:0] dut_rows();
    return {o_row0, o_row1, o_row2, o_row3};
  endfunction

  task automatic push_tick();
    exp_t e;
    m_count = m_count + 32'd1;
    e.mode = m_mode[1:0];
    e.rows = model_rows(m_mode, m_count);
    sb.push_back(e);
  endtask

  // Monitor: every o_tick pulse pops one expected frame.
  always @(negedge clk) begin
    exp_t e;
    if (o_tick === 1'b1) begin
      tick_times.push_back(cyc);
      if (sb_en) begin
        check("tick_expected", sb.size() > 0, 1'b1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          check("tick_mode", o_mode, e.mode);
          check("tick_rows", dut_rows(), e.rows);
        end
      end
    end
  end

  task automatic press(input int b, input int hold, input int gap);
    @(negedge clk);
    btn[b] = 1'b0;
    repeat (hold) @(negedge clk);
    btn[b] = 1'b1;
    repeat (gap) @(negedge clk);
  endtask

  task automatic rnd_press(input int b);
    press(b, 8 + $urandom_range(0, 4), 8 + $urandom_range(0, 4));
  endtask

  task automatic do_step();
    if (!m_running) push_tick();
    rnd_press(1);
    check("sb_drained_after_step", sb.size(), 0);
  endtask

  task automatic do_mode();
    m_mode  = (m_mode + 1) % 4;
    m_count = 32'd0;
    rnd_press(2);
    check("mode_after_press", o_mode, m_mode[1:0]);
    check("rows_after_mode", dut_rows(), model_rows(m_mode, m_count));
  endtask

  task automatic do_glitch();
    int b;
    b = $urandom_range(0, 3);
    @(negedge clk);
    btn[b] = 1'b0;
    repeat (2) @(negedge clk);
    btn[b] = 1'b1;
    repeat (8) @(negedge clk);
    check("glitch_running", o_running, m_running);
    check("glitch_mode", o_mode, m_mode[1:0]);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    t0 = cyc;
    m_mode = 0; m_count = 32'd0; m_running = 1'b1; m_speed = 0;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic wait_ticks(input int n, input int budget);
    int start, k;
    start = tick_times.size();
    k = 0;
    while (tick_times.size() < start + n && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("tick_wait_in_budget", tick_times.size() >= start + n, 1'b1);
  endtask

  initial begin
    int op;
    btn = 4'hF;
    rst = 1'b1;
    m_mode = 0; m_count = 32'd0; m_running = 1'b1; m_speed = 0;
    repeat (3) @(negedge clk);
    check("rst_rows", dut_rows(), 32'hAA55AA55);
    check("rst_mode", o_mode, 2'd0);
    check("rst_running", o_running, 1'b1);
    check("rst_tick", o_tick, 1'b0);
    rst = 1'b0;
    t0 = cyc;

    // Free-running ticks at 16 and 32; a step while running adds nothing.
    push_tick();
    push_tick();
    wait_until(t0 + 16);
    press(1, 8, 8);
    press(0, 8, 8);
    m_running = 1'b0;
    check("pause_running", o_running, 1'b0);
    check("run_tick_count", tick_times.size(), 2);
    if (tick_times.size() >= 2) begin
      check("first_tick_cycle", tick_times[0] - t0, 16);
      check("second_tick_cycle", tick_times[1] - t0, 32);
    end
    repeat (40) @(negedge clk);
    check("no_ticks_in_pause", tick_times.size(), 2);

    do_step();
    do_step();

    // Random mix of steps, mode/speed presses and short glitches while paused.
    repeat (30) begin
      op = $urandom_range(0, 9);
      if (op < 6) do_step();
      else if (op == 6) do_mode();
      else if (op == 7) begin m_speed = (m_speed + 1) % 4; rnd_press(3); end
      else do_glitch();
    end

    do do_mode(); while (m_mode != 1);
    repeat (3) do_step();
    check("counter_rows", dut_rows(), 32'hFFFFFFFC);

    do do_mode(); while (m_mode != 2);
    repeat (9) do_step();
    check("walk_p9_rows", dut_rows(), 32'hFFFDFFFF);
    repeat (23) do_step();
    check("walk_wrap_rows", dut_rows(), 32'hFEFFFFFF);

    do_mode();
    repeat (32) do_step();
    check("fill_full_rows", dut_rows(), 32'h00000000);
    do_step();
    check("fill_wrap_rows", dut_rows(), 32'hFFFFFFFF);

    // Tick spacing per speed, checked on ticks that follow each speed press.
    sb_en = 1'b0;
    do_reset();
    for (int s = 0; s < 4; s++) begin
      press(3, 8, 8);
      m_speed = (m_speed + 1) % 4;
      wait_ticks(3, 120);
      if (tick_times.size() >= 2)
        check("tick_spacing", tick_times[$] - tick_times[$-1], TICK_DIV >> m_speed);
    end

    // Asynchronous reset mid-prescale with a non-zero mode.
    press(2, 8, 8);
    check("mode_before_reset", o_mode, 2'd1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_rst_rows", dut_rows(), 32'hAA55AA55);
    check("async_rst_mode", o_mode, 2'd0);
    check("async_rst_running", o_running, 1'b1);
    check("async_rst_tick", o_tick, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Reset mid-debounce: no event afterwards, prescaler restarts from zero.
    btn[0] = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    btn[0] = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    t0 = cyc;
    m_mode = 0; m_count = 32'd0; m_running = 1'b1; m_speed = 0;
    sb_en = 1'b1;
    push_tick();
    wait_ticks(1, 40);
    if (tick_times.size() >= 1) check("tick_after_reset", tick_times[$] - t0, 16);
    check("running_after_reset", o_running, 1'b1);
    check("sb_empty_at_end", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
